// File: rtl/cmos_init_ctrl.sv
// cmos_init_ctrl: camera power/reset sequencing, SCCB start pulse and vsync watchdog with bounded retries.
module cmos_init_ctrl #(
    parameter logic [19:0] PWDN_DLY    = 20'd24000,
    parameter logic [19:0] RST_DLY     = 20'd240000,
    parameter logic [19:0] BOOT_DLY    = 20'd264000,
    parameter logic [23:0] CFG_TIMEOUT = 24'd12000000,
    parameter logic [23:0] VS_TIMEOUT  = 24'd4800000,
    parameter logic [3:0]  MAX_RETRY   = 4'd3
) (
    input  logic       clk_24m,
    input  logic       rst_n,
    input  logic       cmos_vsync,
    input  logic       sccb_cfg_done,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       sccb_rst_n,
    output logic       sccb_start,
    output logic       cap_en,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic       fault
);
    localparam logic [2:0] PWDN  = 3'd0;
    localparam logic [2:0] RSTH  = 3'd1;
    localparam logic [2:0] BOOT  = 3'd2;
    localparam logic [2:0] CFG   = 3'd3;
    localparam logic [2:0] RUN   = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;
    // Each limit is the last counter value of its window, so a state lasts exactly N cycles.
    localparam logic [23:0] PWDN_END = 24'(PWDN_DLY) - 24'd1;
    localparam logic [23:0] RST_END  = 24'(RST_DLY) - 24'd1;
    localparam logic [23:0] BOOT_END = 24'(BOOT_DLY) - 24'd1;
    localparam logic [23:0] CFG_END  = CFG_TIMEOUT - 24'd1;
    localparam logic [23:0] VS_END   = VS_TIMEOUT - 24'd1;
    logic [2:0]  state_nxt;
    logic [23:0] cnt;
    logic        vs_s1, vs_s2, vs_s3;
    logic        vs_rise, cfg_ok, cfg_fail, run_fail, fail, retry_last;
    assign vs_rise    = vs_s2 & ~vs_s3;
    assign cfg_ok     = state == CFG && cnt != '0 && sccb_cfg_done;
    assign cfg_fail   = state == CFG && !cfg_ok && cnt == CFG_END;
    // An edge landing on the final watchdog cycle still counts as a live frame.
    assign run_fail   = state == RUN && !vs_rise && cnt == VS_END;
    assign fail       = cfg_fail | run_fail;
    assign retry_last = retry_cnt >= MAX_RETRY - 4'd1;
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) state <= PWDN;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            PWDN:    state_nxt = cnt == PWDN_END ? RSTH : PWDN;
            RSTH:    state_nxt = cnt == RST_END ? BOOT : RSTH;
            BOOT:    state_nxt = cnt == BOOT_END ? CFG : BOOT;
            CFG:     state_nxt = cfg_ok ? RUN : cfg_fail ? (retry_last ? FAULT : PWDN) : CFG;
            RUN:     state_nxt = run_fail ? (retry_last ? FAULT : PWDN) : RUN;
            default: state_nxt = FAULT;
        endcase
    end
    always_comb begin
        cmos_pwdn  = !(state == RSTH || state == BOOT || state == CFG || state == RUN);
        cmos_rst_n = state == BOOT || state == CFG || state == RUN;
        sccb_rst_n = state == CFG || state == RUN;
        sccb_start = state == CFG && cnt == '0;
        fault      = state == FAULT;
    end
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (state_nxt != state || (state == RUN && vs_rise)) ? '0 : (&cnt) ? cnt : cnt + 24'd1;
    end
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) retry_cnt <= '0;
        else        retry_cnt <= fail ? (retry_last ? MAX_RETRY : retry_cnt + 4'd1) : (state == RUN && vs_rise) ? 4'd0 : retry_cnt;
    end
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) cap_en <= 1'b0;
        else        cap_en <= state == RUN && state_nxt == RUN;
    end
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) {vs_s1, vs_s2, vs_s3} <= '0;
        else        {vs_s1, vs_s2, vs_s3} <= {cmos_vsync, vs_s1, vs_s2};
    end
endmodule

// File: tb/tb_cmos_init_ctrl.sv
// tb_cmos_init_ctrl: directed bring-up, timeout, watchdog and reset scenarios with cycle-exact expectations.
module tb_cmos_init_ctrl;
    localparam logic [2:0] S_PWDN = 3'd0, S_RSTH = 3'd1, S_BOOT = 3'd2, S_CFG = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5;
    logic       clk_24m = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmos_vsync = 1'b0;
    logic       sccb_cfg_done = 1'b0;
    logic       cmos_pwdn, cmos_rst_n, sccb_rst_n, sccb_start, cap_en, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    int n_chk = 0;
    int n_fail = 0;

    cmos_init_ctrl #(
        .PWDN_DLY(20'd4), .RST_DLY(20'd8), .BOOT_DLY(20'd16),
        .CFG_TIMEOUT(24'd100), .VS_TIMEOUT(24'd50), .MAX_RETRY(4'd2)
    ) dut (
        .clk_24m(clk_24m), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .sccb_cfg_done(sccb_cfg_done),
        .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n), .sccb_rst_n(sccb_rst_n), .sccb_start(sccb_start),
        .cap_en(cap_en), .state(state), .retry_cnt(retry_cnt), .fault(fault)
    );

    always #5 clk_24m = ~clk_24m;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_24m);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [12:0] got;
        got = {state, cmos_pwdn, cmos_rst_n, sccb_rst_n, sccb_start, cap_en, retry_cnt, fault};
        n_chk++;
        if (got !== {S_PWDN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: {state,pwdn,rst_n,sccb_rst_n,start,cap_en,retry,fault}=%b expected %b", name, got,
                     {S_PWDN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmos_vsync = 1'b0;
        sccb_cfg_done = 1'b0;
        step(3);
        check_reset_outputs("reset_values");
    endtask

    // Called at cycle 0 (first cycle after rst_n release); ends in RUN at cycle 39.
    task automatic test_nominal;
        int starts;
        sccb_cfg_done = 1'b0;
        n_chk++;
        if (state !== S_PWDN || cmos_pwdn !== 1'b1) begin n_fail++; $display("FAIL nom_c0: state=%0d pwdn=%b expected 0/1", state, cmos_pwdn); end
        step(3);
        n_chk++;
        if (cmos_pwdn !== 1'b1) begin n_fail++; $display("FAIL nom_c3_pwdn: got %b expected 1", cmos_pwdn); end
        step(1);
        n_chk++;
        if (cmos_pwdn !== 1'b0 || state !== S_RSTH || cmos_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL nom_c4: pwdn=%b state=%0d rst_n=%b expected 0/1/0", cmos_pwdn, state, cmos_rst_n);
        end
        step(7);
        n_chk++;
        if (cmos_rst_n !== 1'b0) begin n_fail++; $display("FAIL nom_c11_rst_n: got %b expected 0", cmos_rst_n); end
        step(1);
        n_chk++;
        if (cmos_rst_n !== 1'b1 || state !== S_BOOT) begin n_fail++; $display("FAIL nom_c12: rst_n=%b state=%0d expected 1/2", cmos_rst_n, state); end
        step(15);
        n_chk++;
        if (state !== S_BOOT || sccb_start !== 1'b0 || sccb_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL nom_c27: state=%0d start=%b sccb_rst_n=%b expected 2/0/0", state, sccb_start, sccb_rst_n);
        end
        step(1);
        n_chk++;
        if (state !== S_CFG || sccb_start !== 1'b1 || sccb_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL nom_c28: state=%0d start=%b sccb_rst_n=%b expected 3/1/1", state, sccb_start, sccb_rst_n);
        end
        starts = 0;
        for (int c = 29; c <= 37; c++) begin
            step(1);
            if (sccb_start === 1'b1) starts++;
        end
        n_chk++;
        if (starts != 0 || state !== S_CFG) begin n_fail++; $display("FAIL nom_single_start: extra pulses=%0d state=%0d expected 0/3", starts, state); end
        sccb_cfg_done = 1'b1;
        step(1);
        n_chk++;
        if (state !== S_RUN || cap_en !== 1'b0) begin n_fail++; $display("FAIL nom_c38: state=%0d cap_en=%b expected 4/0", state, cap_en); end
        step(1);
        n_chk++;
        if (cap_en !== 1'b1) begin n_fail++; $display("FAIL nom_c39_cap_en: got %b expected 1", cap_en); end
    endtask

    // From RUN cycle 39 (call it k): vsync raised at k, k+40, k+80; last detected edge at k+82, timeout lands at k+133.
    task automatic test_vsync_watchdog;
        int bad;
        bad = 0;
        for (int t = 0; t <= 132; t++) begin
            cmos_vsync = (t <= 82) && (t % 40 < 3);
            step(1);
            if (t + 1 < 133 && (state !== S_RUN || cap_en !== 1'b1)) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL wd_run_kept: %0d cycles left RUN early, expected 0", bad); end
        n_chk++;
        if (state !== S_PWDN || cap_en !== 1'b0 || retry_cnt !== 4'd1 || sccb_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL wd_timeout: state=%0d cap_en=%b retry=%0d sccb_rst_n=%b expected 0/0/1/0", state, cap_en, retry_cnt, sccb_rst_n);
        end
    endtask

    // From PWDN cycle 0 with retry_cnt=1: RUN at 38, edges detected at 42 and 92 (counter at 49 on the second).
    task automatic test_retry_clear_boundary;
        sccb_cfg_done = 1'b0;
        step(37);
        sccb_cfg_done = 1'b1;
        step(1);
        n_chk++;
        if (state !== S_RUN) begin n_fail++; $display("FAIL rc_run_entry: state=%0d expected 4", state); end
        for (int t = 38; t <= 142; t++) begin
            cmos_vsync = (t >= 40 && t < 43) || (t >= 90 && t < 93);
            step(1);
            if (t + 1 == 42) begin
                n_chk++;
                if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL rc_before_edge: retry=%0d expected 1", retry_cnt); end
            end
            if (t + 1 == 43) begin
                n_chk++;
                if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL rc_cleared: retry=%0d expected 0", retry_cnt); end
            end
            if (t + 1 == 93) begin
                n_chk++;
                if (state !== S_RUN || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL boundary_edge: state=%0d retry=%0d expected 4/0", state, retry_cnt); end
            end
            if (t + 1 == 142) begin
                n_chk++;
                if (state !== S_RUN) begin n_fail++; $display("FAIL boundary_hold: state=%0d expected 4", state); end
            end
        end
        n_chk++;
        if (state !== S_PWDN || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL boundary_timeout: state=%0d retry=%0d expected 0/1", state, retry_cnt); end
    endtask

    task automatic test_reset_mid_run;
        sccb_cfg_done = 1'b0;
        step(37);
        sccb_cfg_done = 1'b1;
        step(2);
        n_chk++;
        if (state !== S_RUN || cap_en !== 1'b1 || retry_cnt !== 4'd1) begin
            n_fail++; $display("FAIL mid_pre: state=%0d cap_en=%b retry=%0d expected 4/1/1", state, cap_en, retry_cnt);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_async_reset");
        step(1);
        rst_n = 1'b1;
        test_nominal;
    endtask

    task automatic test_cfg_timeout;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        sccb_cfg_done = 1'b0;
        step(127);
        n_chk++;
        if (state !== S_CFG || sccb_rst_n !== 1'b1) begin n_fail++; $display("FAIL cfg_to1_last: state=%0d sccb_rst_n=%b expected 3/1", state, sccb_rst_n); end
        step(1);
        n_chk++;
        if (state !== S_PWDN || retry_cnt !== 4'd1 || sccb_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL cfg_to1: state=%0d retry=%0d sccb_rst_n=%b expected 0/1/0", state, retry_cnt, sccb_rst_n);
        end
        step(127);
        n_chk++;
        if (state !== S_CFG || fault !== 1'b0) begin n_fail++; $display("FAIL cfg_to2_last: state=%0d fault=%b expected 3/0", state, fault); end
        step(1);
        n_chk++;
        if (state !== S_FAULT || retry_cnt !== 4'd2 || fault !== 1'b1 || cmos_pwdn !== 1'b1 || cmos_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL cfg_to2: state=%0d retry=%0d fault=%b pwdn=%b rst_n=%b expected 5/2/1/1/0",
                               state, retry_cnt, fault, cmos_pwdn, cmos_rst_n);
        end
    endtask

    task automatic test_fault_terminal;
        int bad;
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            cmos_vsync = (t % 20) < 5;
            sccb_cfg_done = t[3];
            step(1);
            if (state !== S_FAULT || fault !== 1'b1 || cap_en !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL fault_sticky: %0d cycles out of FAULT, expected 0", bad); end
        rst_n = 1'b0;
        step(1);
        check_reset_outputs("fault_cleared_by_reset");
        rst_n = 1'b1;
        step(4);
        n_chk++;
        if (state !== S_RSTH) begin n_fail++; $display("FAIL fault_restart: state=%0d expected 1", state); end
    endtask

    initial begin
        test_reset;
        rst_n = 1'b1;
        test_nominal;
        test_vsync_watchdog;
        test_retry_clear_boundary;
        test_reset_mid_run;
        test_cfg_timeout;
        test_fault_terminal;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmos_init_ctrl.md
CMOS_INIT_CTRL -- requirements
Module: cmos_init_ctrl

Interface
REQ-001 SHALL have parameter PWDN_DLY, default 20'd24000, cycles cmos_pwdn held high per power cycle.
REQ-002 SHALL have parameter RST_DLY, default 20'd240000, cycles cmos_rst_n held low after pwdn release.
REQ-003 SHALL have parameter BOOT_DLY, default 20'd264000, cycles after reset release before SCCB configuration.
REQ-004 SHALL have parameter CFG_TIMEOUT, default 24'd12000000, max cycles waiting for sccb_cfg_done.
REQ-005 SHALL have parameter VS_TIMEOUT, default 24'd4800000, max cycles between vsync rising edges in RUN.
REQ-006 SHALL have parameter MAX_RETRY, default 4'd3, consecutive failed bring-ups before FAULT.
REQ-007 SHALL have port clk_24m, input, 1, system clock 24 MHz.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port cmos_vsync, input, 1, camera frame sync, asynchronous to clk_24m.
REQ-010 SHALL have port sccb_cfg_done, input, 1, level high once the register table is fully written.
REQ-011 SHALL have port cmos_pwdn, output, 1, camera power-down, high = powered down.
REQ-012 SHALL have port cmos_rst_n, output, 1, camera hardware reset, active-low.
REQ-013 SHALL have port sccb_rst_n, output, 1, active-low reset to the SCCB config sequencer.
REQ-014 SHALL have port sccb_start, output, 1, single-cycle pulse that starts SCCB configuration.
REQ-015 SHALL have port cap_en, output, 1, enables the capture path.
REQ-016 SHALL have port state, output, 3, current FSM state code.
REQ-017 SHALL have port retry_cnt, output, 4, consecutive failure count.
REQ-018 SHALL have port fault, output, 1, sticky bring-up failure flag.

Function
REQ-019 SHALL implement FSM states PWDN=0, RSTH=1, BOOT=2, CFG=3, RUN=4, FAULT=5; codes 6-7 SHALL go to FAULT.
REQ-020 SHALL use one shared delay counter, cleared on every state change, so PWDN, RSTH and BOOT each last exactly PWDN_DLY, RST_DLY and BOOT_DLY cycles.
REQ-021 SHALL drive outputs per state: PWDN pwdn=1 rst_n=0; RSTH pwdn=0 rst_n=0; BOOT/CFG/RUN pwdn=0 rst_n=1; FAULT pwdn=1 rst_n=0.
REQ-022 SHALL hold sccb_rst_n=0 in PWDN, RSTH, BOOT and FAULT, and sccb_rst_n=1 in CFG and RUN.
REQ-023 SHALL pulse sccb_start high for exactly the first clk_24m cycle of CFG.
REQ-024 SHALL go from CFG to RUN on the first cycle sccb_cfg_done=1, sampled no earlier than the second CFG cycle.
REQ-025 SHALL treat CFG as failed when the counter reaches CFG_TIMEOUT without sccb_cfg_done.
REQ-026 SHALL assert cap_en only in RUN, registered, rising one cycle after RUN entry.
REQ-027 SHALL synchronise cmos_vsync through two flops, and detect rising edges with a third flop.
REQ-028 SHALL clear the counter on each synced vsync rising edge in RUN, and treat RUN as failed when the counter reaches VS_TIMEOUT.
REQ-029 SHALL clear retry_cnt to 0 on the first vsync rising edge in RUN.
REQ-030 SHALL handle a failure (CFG timeout or RUN timeout) as follows:
- if retry_cnt < MAX_RETRY-1: increment retry_cnt and go to PWDN;
- otherwise: set retry_cnt=MAX_RETRY and go to FAULT.
REQ-031 SHALL count a vsync edge that coincides with the VS_TIMEOUT cycle as a valid edge, with no failure.
REQ-032 SHALL keep FAULT terminal, with fault=1, until rst_n is asserted.
REQ-033 SHALL use saturating counters that never wrap.

Reset
REQ-034 SHALL, while rst_n=0, force state=PWDN, counter=0, retry_cnt=0, cmos_pwdn=1, cmos_rst_n=0, sccb_rst_n=0, sccb_start=0, cap_en=0, fault=0 and sync flops=0.
REQ-035 SHALL restart from PWDN with a full sequence when rst_n is asserted mid-operation in any state.

Verification (PWDN_DLY=4, RST_DLY=8, BOOT_DLY=16, CFG_TIMEOUT=100, VS_TIMEOUT=50, MAX_RETRY=2)
REQ-036 SHALL verify nominal bring-up: release rst_n, assert cfg_done 10 cycles into CFG -> pwdn falls at cycle 4, rst_n rises at 12, sccb_start pulses once at 28, RUN at 38, cap_en=1 at 39.
REQ-037 SHALL verify CFG timeout: hold cfg_done=0 -> after 100 CFG cycles state=PWDN, retry_cnt=1, sccb_rst_n=0; second timeout -> state=FAULT, retry_cnt=2, fault=1, pwdn=1.
REQ-038 SHALL verify vsync watchdog: in RUN, give vsync edges every 40 cycles then stop -> no failure while edges continue; 50 cycles after the last edge state=PWDN and cap_en=0.
REQ-039 SHALL verify retry clear: fail once, then bring up and give one vsync edge -> retry_cnt returns to 0.
REQ-040 SHALL verify boundary: vsync edge exactly at counter=VS_TIMEOUT -> remains in RUN.
REQ-041 SHALL verify reset mid-RUN: assert rst_n for 1 cycle -> all outputs at reset values, then a full sequence with identical timing to the nominal case.
